// File: rtl/regbus_master.sv
// regbus_master: single/burst initiator for the simple register bus.
// Write beats follow the WD stream; reads keep one beat outstanding and sample READ_DATA RD_LAT cycles after READ.
module regbus_master #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2,
    parameter int LEN_W  = 3,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic              WD_VALID,
    output logic              WD_READY,
    input  logic [DATA_W-1:0] WD_DATA,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_LAST,
    output logic              DONE,
    output logic              WRITE,
    output logic              READ,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WRITE_DATA,
    input  logic [DATA_W-1:0] READ_DATA
);

    localparam logic [2:0] LAT = 3'(RD_LAT);

    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, FIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  cur_addr, cur_addr_nxt;
    logic [LEN_W-1:0]   remaining, remaining_nxt;
    logic [2:0]         wait_cnt, wait_cnt_nxt;
    logic               write_nxt, read_nxt, rd_valid_nxt, rd_last_nxt, done_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  write_data_nxt, rd_data_nxt;

    assign CMD_READY = (state == IDLE);
    assign WD_READY  = (state == WR);

    always_comb begin
        state_nxt      = state;
        cur_addr_nxt   = cur_addr;
        remaining_nxt  = remaining;
        wait_cnt_nxt   = wait_cnt;
        write_nxt      = 1'b0;
        read_nxt       = 1'b0;
        rd_valid_nxt   = 1'b0;
        rd_last_nxt    = 1'b0;
        done_nxt       = 1'b0;
        addr_nxt       = ADDR;
        write_data_nxt = WRITE_DATA;
        rd_data_nxt    = RD_DATA;

        case (state)
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    cur_addr_nxt  = CMD_ADDR;
                    remaining_nxt = CMD_LEN;
                    state_nxt     = CMD_WRITE ? WR : RD_ISSUE;
                end
            end
            WR: begin
                if (WD_VALID && WD_READY) begin
                    write_nxt      = 1'b1;
                    addr_nxt       = cur_addr;
                    write_data_nxt = WD_DATA;
                    cur_addr_nxt   = cur_addr + 1'b1;
                    if (remaining == '0) state_nxt = FIN;
                    else                 remaining_nxt = remaining - 1'b1;
                end
            end
            RD_ISSUE: begin
                read_nxt     = 1'b1;
                addr_nxt     = cur_addr;
                cur_addr_nxt = cur_addr + 1'b1;
                wait_cnt_nxt = LAT;
                state_nxt    = RD_WAIT;
            end
            RD_WAIT: begin
                // Sample edge doubles as the issue edge of the next beat, so the period is RD_LAT+1.
                if (wait_cnt == '0) begin
                    rd_valid_nxt = 1'b1;
                    rd_data_nxt  = READ_DATA;
                    rd_last_nxt  = (remaining == '0);
                    if (remaining == '0) begin
                        state_nxt = FIN;
                    end else begin
                        remaining_nxt = remaining - 1'b1;
                        read_nxt      = 1'b1;
                        addr_nxt      = cur_addr;
                        cur_addr_nxt  = cur_addr + 1'b1;
                        wait_cnt_nxt  = LAT;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            FIN: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            wait_cnt   <= '0;
            WRITE      <= 1'b0;
            READ       <= 1'b0;
            ADDR       <= '0;
            WRITE_DATA <= '0;
            RD_VALID   <= 1'b0;
            RD_DATA    <= '0;
            RD_LAST    <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_addr   <= cur_addr_nxt;
            remaining  <= remaining_nxt;
            wait_cnt   <= wait_cnt_nxt;
            WRITE      <= write_nxt;
            READ       <= read_nxt;
            ADDR       <= addr_nxt;
            WRITE_DATA <= write_data_nxt;
            RD_VALID   <= rd_valid_nxt;
            RD_DATA    <= rd_data_nxt;
            RD_LAST    <= rd_last_nxt;
            DONE       <= done_nxt;
        end
    end

endmodule
